// File: rtl/ofdm_pkg.sv
// Shared OFDM subcarrier definitions: bin classification and the data address map
// used by both the TX mapper and the RX subcarrier extractor.
package ofdm_pkg;

    localparam int NUM_BINS = 64;
    localparam int NUM_DATA = 48;

    // Pilot slot order: -21, -7, +7, +21 (bins 43, 57, 7, 21)
    localparam logic [5:0] PILOT_BIN      [4] = '{6'd43, 6'd57, 6'd7, 6'd21};
    localparam logic       PILOT_BASE_NEG [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    localparam logic [6:0] SCRAMBLER_SEED = 7'h7F;

    typedef enum logic [1:0] {
        BIN_NULL,
        BIN_PILOT,
        BIN_DATA
    } bin_class_e;

    function automatic bin_class_e bin_class(input logic [5:0] k);
        bin_class_e c;
        case (k) inside
            6'd0, [6'd27:6'd37]:        c = BIN_NULL;
            6'd7, 6'd21, 6'd43, 6'd57:  c = BIN_PILOT;
            default:                    c = BIN_DATA;
        endcase
        return c;
    endfunction

    // Logical data index runs from the most negative frequency (-26) upward.
    function automatic logic [5:0] data_addr(input logic [5:0] k);
        logic [5:0] a;
        if (k <= 6'd6)       a = k + 6'd23;
        else if (k <= 6'd20) a = k + 6'd22;
        else if (k <= 6'd26) a = k + 6'd21;
        else if (k <= 6'd42) a = k - 6'd38;
        else if (k <= 6'd56) a = k - 6'd39;
        else                 a = k - 6'd40;
        return a;
    endfunction

    function automatic logic [1:0] pilot_slot(input logic [5:0] k);
        logic [1:0] s;
        case (k)
            PILOT_BIN[0]: s = 2'd0;
            PILOT_BIN[1]: s = 2'd1;
            PILOT_BIN[2]: s = 2'd2;
            default:      s = 2'd3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rx_pilot_scrambler.sv
// 7-bit pilot polarity LFSR (x^7 + x^4 + 1); polarity=1 means the symbol's pilots are inverted.
module rx_pilot_scrambler
    import ofdm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic step,
    output logic polarity
);

    logic [6:0] lfsr;

    // NOTE: sequential state is always updated with <=, so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= SCRAMBLER_SEED;
        end else if (clear) begin
            lfsr <= SCRAMBLER_SEED;
        end else if (step) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[3]};
        end
    end

    assign polarity = lfsr[6] ^ lfsr[3];

endmodule

// File: rtl/rx_subcarrier_extract.sv
// Collects one 64-bin FFT symbol, emits polarity-corrected pilots immediately and
// drains the 48 data subcarriers in logical index order.
module rx_subcarrier_extract
    import ofdm_pkg::*;
#(
    parameter int DW   = 16,
    parameter int SYMW = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            istream_val,
    output logic            istream_rdy,
    input  logic [DW-1:0]   istream_i,
    input  logic [DW-1:0]   istream_q,
    output logic            ostream_val,
    input  logic            ostream_rdy,
    output logic [DW-1:0]   ostream_i,
    output logic [DW-1:0]   ostream_q,
    output logic [5:0]      ostream_idx,
    output logic            ostream_last,
    output logic            pilot_val,
    output logic [DW-1:0]   pilot_i,
    output logic [DW-1:0]   pilot_q,
    output logic [1:0]      pilot_idx,
    output logic [SYMW-1:0] symbol_cnt
);

    typedef enum logic {FILL, DRAIN} state_e;

    state_e          state_q, state_d;
    logic            active_q;
    logic [5:0]      bin_cnt;
    logic [5:0]      drain_cnt;
    logic [2*DW-1:0] data_buf [NUM_DATA];
    logic [2*DW-1:0] rd_word;
    logic            hs_in, hs_out, drain_last, polarity, pilot_neg;
    bin_class_e      k_class;

    function automatic logic [DW-1:0] sat_neg(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        if (x == {1'b1, {(DW-1){1'b0}}}) r = {1'b0, {(DW-1){1'b1}}};
        else                             r = -x;
        return r;
    endfunction

    // clear outranks any handshake in the same cycle.
    assign hs_in      = istream_val && istream_rdy && !clear;
    assign hs_out     = ostream_val && ostream_rdy && !clear;
    assign drain_last = (drain_cnt == 6'(NUM_DATA - 1));
    assign k_class    = bin_class(bin_cnt);
    assign pilot_neg  = PILOT_BASE_NEG[pilot_slot(bin_cnt)] ^ polarity;

    assign istream_rdy  = active_q && (state_q == FILL);
    assign ostream_val  = (state_q == DRAIN);
    assign rd_word      = data_buf[drain_cnt];
    assign ostream_i    = ostream_val ? rd_word[2*DW-1:DW] : '0;
    assign ostream_q    = ostream_val ? rd_word[DW-1:0]    : '0;
    assign ostream_idx  = drain_cnt;
    assign ostream_last = ostream_val && drain_last;

    rx_pilot_scrambler u_scrambler (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .step     (hs_out && drain_last),
        .polarity (polarity)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (hs_in && bin_cnt == 6'(NUM_BINS - 1)) state_d = DRAIN;
            DRAIN:   if (hs_out && drain_last)                 state_d = FILL;
            default: state_d = FILL;
        endcase
        if (clear) state_d = FILL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FILL;
            active_q   <= 1'b0;
            bin_cnt    <= '0;
            drain_cnt  <= '0;
            symbol_cnt <= '0;
            pilot_val  <= 1'b0;
            pilot_i    <= '0;
            pilot_q    <= '0;
            pilot_idx  <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= 1'b1;
            pilot_val <= 1'b0;
            if (clear) begin
                bin_cnt    <= '0;
                drain_cnt  <= '0;
                symbol_cnt <= '0;
            end else begin
                if (hs_in) begin
                    bin_cnt <= bin_cnt + 6'd1;
                    if (k_class == BIN_PILOT) begin
                        pilot_val <= 1'b1;
                        pilot_i   <= pilot_neg ? sat_neg(istream_i) : istream_i;
                        pilot_q   <= pilot_neg ? sat_neg(istream_q) : istream_q;
                        pilot_idx <= pilot_slot(bin_cnt);
                    end
                end
                if (hs_out) begin
                    if (drain_last) begin
                        drain_cnt  <= '0;
                        symbol_cnt <= symbol_cnt + SYMW'(1);
                    end else begin
                        drain_cnt <= drain_cnt + 6'd1;
                    end
                end
            end
        end
    end

    // NOTE: the symbol buffer has no reset; every entry is rewritten before it is drained.
    always_ff @(posedge clk) begin
        if (hs_in && k_class == BIN_DATA) begin
            data_buf[data_addr(bin_cnt)] <= {istream_i, istream_q};
        end
    end

endmodule

// File: tb/tb_rx_subcarrier_extract.sv
// Randomized bench for rx_subcarrier_extract with a frequency-domain reference model.
module tb_rx_subcarrier_extract;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        istream_val = 1'b0;
    logic        istream_rdy;
    logic [15:0] istream_i = '0, istream_q = '0;
    logic        ostream_val;
    logic        ostream_rdy = 1'b0;
    logic [15:0] ostream_i, ostream_q;
    logic [5:0]  ostream_idx;
    logic        ostream_last;
    logic        pilot_val;
    logic [15:0] pilot_i, pilot_q;
    logic [1:0]  pilot_idx;
    logic [11:0] symbol_cnt;

    rx_subcarrier_extract #(.DW(16), .SYMW(12)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .istream_val(istream_val), .istream_rdy(istream_rdy),
        .istream_i(istream_i), .istream_q(istream_q),
        .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
        .ostream_i(ostream_i), .ostream_q(ostream_q),
        .ostream_idx(ostream_idx), .ostream_last(ostream_last),
        .pilot_val(pilot_val), .pilot_i(pilot_i), .pilot_q(pilot_q),
        .pilot_idx(pilot_idx), .symbol_cnt(symbol_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] i;
        logic [15:0] q;
    } pilot_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          data_bin [48];
    int          pol_seq [263];
    logic [15:0] cur_i [64];
    logic [15:0] cur_q [64];
    pilot_t      pilot_q_exp [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int freq_of(input int bin);
        return (bin < 32) ? bin : bin - 64;
    endfunction

    // Polarity bit of symbol n: o[n] = o[n-7] ^ o[n-4], seeded with seven ones.
    function automatic int pol_bit(input int sym);
        return pol_seq[(sym % 127) + 7];
    endfunction

    function automatic logic [15:0] apply_sign(input logic [15:0] v, input bit neg);
        int x;
        x = int'($signed(v));
        if (neg) x = -x;
        if (x > 32767) x = 32767;
        return 16'(x);
    endfunction

    function automatic bit is_pilot(input int bin);
        int f;
        f = freq_of(bin);
        return (f == 7) || (f == -7) || (f == 21) || (f == -21);
    endfunction

    task automatic gen_symbol(input int sym);
        for (int k = 0; k < 64; k++) begin
            if (sym == 0) begin
                cur_i[k] = 16'(k);
                cur_q[k] = 16'(-k);
            end else begin
                cur_i[k] = 16'($urandom);
                cur_q[k] = 16'($urandom);
                if ((k == 7 || k == 21) && (sym % 3 == 0)) cur_i[k] = 16'h8000;
            end
        end
    endtask

    task automatic pilot_only_symbol(input logic [15:0] val);
        for (int k = 0; k < 64; k++) begin
            cur_i[k] = is_pilot(k) ? val : 16'($urandom);
            cur_q[k] = is_pilot(k) ? 16'h0000 : 16'($urandom);
        end
    endtask

    task automatic push_sample(input int k, input bit gaps, input int pol_sym);
        int guard;
        int f;
        guard = 0;
        while (gaps && $urandom_range(0, 3) == 0) begin
            istream_val = 1'b0;
            @(posedge clk);
            #1;
        end
        if (is_pilot(k)) begin
            pilot_t p;
            bit neg;
            f = freq_of(k);
            neg = ((f == 21) ? 1'b1 : 1'b0) ^ (pol_bit(pol_sym) != 0);
            p.idx = (f == -21) ? 0 : (f == -7) ? 1 : (f == 7) ? 2 : 3;
            p.i = apply_sign(cur_i[k], neg);
            p.q = apply_sign(cur_q[k], neg);
            pilot_q_exp.push_back(p);
        end
        istream_val = 1'b1;
        istream_i   = cur_i[k];
        istream_q   = cur_q[k];
        @(negedge clk);
        while (!istream_rdy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!istream_rdy) check("istream_rdy_timeout", 32'(istream_rdy), 32'd1);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
    endtask

    task automatic feed(input int from, input int to, input bit gaps, input int pol_sym);
        for (int k = from; k <= to; k++) push_sample(k, gaps, pol_sym);
    endtask

    task automatic drain(input bit rnd, input int exp_cnt);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < 48 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (ostream_val) begin
                check("drain_istream_rdy", 32'(istream_rdy), 32'd0);
                check("data_idx", 32'(ostream_idx), 32'(idx));
                check("data_i", 32'(ostream_i), 32'(cur_i[data_bin[idx]]));
                check("data_q", 32'(ostream_q), 32'(cur_q[data_bin[idx]]));
                check("data_last", 32'(ostream_last), (idx == 47) ? 32'd1 : 32'd0);
                ostream_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (ostream_rdy) idx++;
            end else begin
                ostream_rdy = 1'b0;
            end
        end
        if (idx < 48) check("drain_timeout", 32'(idx), 32'd48);
        @(posedge clk);
        #1;
        ostream_rdy = 1'b0;
        check("symbol_cnt", 32'(symbol_cnt), 32'(exp_cnt));
        check("refill_rdy", 32'(istream_rdy), 32'd1);
    endtask

    always @(negedge clk) begin
        if (pilot_val) begin
            if (pilot_q_exp.size() == 0) begin
                check("pilot_unexpected", 32'(pilot_val), 32'd0);
            end else begin
                pilot_t p;
                p = pilot_q_exp.pop_front();
                check("pilot_idx", 32'(pilot_idx), 32'(p.idx));
                check("pilot_i", 32'(pilot_i), 32'(p.i));
                check("pilot_q", 32'(pilot_q), 32'(p.q));
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_ostream_val"}, 32'(ostream_val), 32'd0);
        check({tag, "_ostream_last"}, 32'(ostream_last), 32'd0);
        check({tag, "_pilot_val"}, 32'(pilot_val), 32'd0);
        check({tag, "_symbol_cnt"}, 32'(symbol_cnt), 32'd0);
    endtask

    initial begin
        int n;
        int sym;

        // Logical data order: frequencies -26..+26 skipping DC and pilots.
        n = 0;
        for (int f = -26; f <= 26; f++) begin
            if (f != 0 && !is_pilot((f < 0) ? f + 64 : f)) begin
                data_bin[n] = (f < 0) ? f + 64 : f;
                n++;
            end
        end
        for (int j = 0; j < 7; j++) pol_seq[j] = 1;
        for (int j = 7; j < 263; j++) pol_seq[j] = pol_seq[j-7] ^ pol_seq[j-4];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_istream_rdy", 32'(istream_rdy), 32'd0);
        check("reset_ostream_i", 32'(ostream_i), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("release_istream_rdy", 32'(istream_rdy), 32'd1);

        // Ramp symbol, then random symbols through a full scrambler period and beyond
        for (sym = 0; sym < 130; sym++) begin
            if (sym == 1) pilot_only_symbol(16'd1000);
            else gen_symbol(sym);
            feed(0, 63, sym % 2 == 1, sym);
            drain(sym % 2 == 0 && sym > 0, sym + 1);
        end

        // clear arriving with a sample at bin 30 of a symbol
        gen_symbol(sym);
        feed(0, 29, 1'b1, sym);
        istream_val = 1'b1;
        istream_i   = cur_i[30];
        istream_q   = cur_q[30];
        clear       = 1'b1;
        @(posedge clk);
        #1;
        clear       = 1'b0;
        istream_val = 1'b0;
        check_idle("clear");
        check("clear_istream_rdy", 32'(istream_rdy), 32'd1);
        gen_symbol(3);
        feed(0, 63, 1'b0, 0);
        drain(1'b1, 1);

        // Asynchronous reset in the middle of a drain
        gen_symbol(6);
        feed(0, 63, 1'b1, 1);
        @(negedge clk);
        ostream_rdy = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_idle("abort");
        check("abort_istream_rdy", 32'(istream_rdy), 32'd0);
        ostream_rdy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_release_rdy", 32'(istream_rdy), 32'd1);
        check("abort_release_val", 32'(ostream_val), 32'd0);
        gen_symbol(9);
        feed(0, 63, 1'b0, 0);
        drain(1'b0, 1);

        repeat (3) @(negedge clk);
        check("pilot_pending", 32'(pilot_q_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
